// File: rtl/vme_pkg.sv
// vme_pkg: shared VME signal levels, A24 address modifiers and responder state encoding.
package vme_pkg;
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;
  localparam logic DIR_IN   = 1'b1;
  localparam logic DIR_OUT  = 1'b0;
  localparam logic [5:0] AM_A24_UD = 6'h39;
  localparam logic [5:0] AM_A24_UP = 6'h3A;
  localparam logic [5:0] AM_A24_SD = 6'h3D;
  localparam logic [5:0] AM_A24_SP = 6'h3E;
  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACCESS,
    ACK,
    BERR_ST,
    RELEASE,
    IGNORE
  } state_e;
  function automatic logic am_a24(input logic [5:0] am);
    return am inside {AM_A24_UD, AM_A24_UP, AM_A24_SD, AM_A24_SP};
  endfunction
endpackage

// File: rtl/vme_sync.sv
// vme_sync: multi-bit flop-chain synchroniser, resets to all ones (strobes released).
module vme_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sync_q [STAGES];
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/vme_slave_responder.sv
// vme_slave_responder: VME A24 slave decoding the card window into single local-bus transfers.
module vme_slave_responder
  import vme_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR      = 8'hF0,
  parameter logic [7:0] BASE_MASK      = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        vme_as_i,
  input  logic [1:0]  vme_ds_i,
  input  logic        vme_lword_i,
  input  logic        vme_write_i,
  input  logic [5:0]  vme_address_mod_i,
  input  logic [22:0] vme_address_i,
  input  logic        vme_iack_i,
  output logic        vme_dtack_o,
  output logic        vme_berr_o,
  output logic        data_oe_o,
  output logic        data_dir_o,
  output logic        local_req_o,
  output logic        local_write_o,
  output logic [21:0] local_addr_o,
  output logic [3:0]  local_be_o,
  input  logic        local_ack_i,
  input  logic        local_err_i,
  output logic        busy_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0] strobe_s;
  logic as_s;
  logic [1:0] ds_s;
  state_e state_q;
  logic [22:0] addr_q;
  logic lword_q, write_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dtack_q, berr_q, oe_q, dir_q, req_q, lwrite_q;
  logic [21:0] laddr_q;
  logic [3:0] be_q, be_d;
  logic hit, illegal, timeout;
  vme_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     ({vme_as_i, vme_ds_i}),
    .q_o     (strobe_s)
  );
  assign as_s = strobe_s[2];
  assign ds_s = strobe_s[1:0];
  always_comb begin
    hit     = vme_iack_i && am_a24(vme_address_mod_i) &&
              (((vme_address_i[22:15] ^ BASE_ADDR) & BASE_MASK) == 8'h00);
    illegal = !lword_q && (addr_q[0] || ds_s != 2'b00);
    be_d    = !lword_q ? 4'b1111 : addr_q[0] ? {2'b00, ~ds_s} : {~ds_s, 2'b00};
    cnt_d   = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    timeout = cnt_q >= CW'(TIMEOUT_CYCLES - 1);
  end
  // vme_write is active low: write_q == 1 means a read, so the card drives the bus.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      lword_q  <= 1'b1;
      write_q  <= 1'b1;
      cnt_q    <= '0;
      dtack_q  <= INACTIVE;
      berr_q   <= INACTIVE;
      oe_q     <= INACTIVE;
      dir_q    <= DIR_IN;
      req_q    <= 1'b0;
      lwrite_q <= 1'b0;
      laddr_q  <= '0;
      be_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (!as_s) begin
          addr_q  <= vme_address_i;
          lword_q <= vme_lword_i;
          write_q <= vme_write_i;
          state_q <= hit ? DECODE : IGNORE;
        end
        DECODE: if (ds_s != 2'b11) begin
          if (illegal) begin
            state_q <= BERR_ST;
            berr_q  <= ACTIVE;
            oe_q    <= INACTIVE;
          end else begin
            state_q  <= ACCESS;
            req_q    <= 1'b1;
            lwrite_q <= !write_q;
            laddr_q  <= addr_q[22:1];
            be_q     <= be_d;
            dir_q    <= write_q ? DIR_OUT : DIR_IN;
            oe_q     <= ACTIVE;
            cnt_q    <= '0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_d;
          if (local_err_i || timeout) begin
            req_q   <= 1'b0;
            state_q <= BERR_ST;
            berr_q  <= ACTIVE;
            oe_q    <= INACTIVE;
          end else if (local_ack_i) begin
            req_q   <= 1'b0;
            state_q <= ACK;
            dtack_q <= ACTIVE;
          end
        end
        ACK: if (ds_s == 2'b11 && as_s) begin
          state_q <= RELEASE;
          dtack_q <= INACTIVE;
          oe_q    <= INACTIVE;
          dir_q   <= DIR_IN;
        end
        BERR_ST: if (ds_s == 2'b11) begin
          state_q <= RELEASE;
          berr_q  <= INACTIVE;
          oe_q    <= INACTIVE;
          dir_q   <= DIR_IN;
        end
        RELEASE: state_q <= IDLE;
        IGNORE: if (as_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign vme_dtack_o   = dtack_q;
  assign vme_berr_o    = berr_q;
  assign data_oe_o     = oe_q;
  assign data_dir_o    = dir_q;
  assign local_req_o   = req_q;
  assign local_write_o = lwrite_q;
  assign local_addr_o  = laddr_q;
  assign local_be_o    = be_q;
  assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_vme_slave_responder.sv
// tb_vme_slave_responder: directed and randomized VME cycles checked against a transaction-level model.
module tb_vme_slave_responder;
  import vme_pkg::*;
  localparam int TO = 255;
  localparam int SS = 2;
  logic clock = 0, reset = 1;
  logic vme_as = 1, vme_lword = 1, vme_write = 1, vme_iack = 1;
  logic [1:0] vme_ds = 2'b11;
  logic [5:0] vme_address_mod = 6'h3D;
  logic [22:0] vme_address = '0;
  logic vme_dtack, vme_berr, data_oe, data_dir, local_req, local_write, busy;
  logic [21:0] local_addr;
  logic [3:0] local_be;
  logic local_ack = 0, local_err = 0;
  int n_checks = 0, n_fail = 0;
  bit req_seen;
  always #5 clock = ~clock;
  vme_slave_responder #(.BASE_ADDR(8'hF0), .BASE_MASK(8'hFF), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clock_i(clock), .reset_i(reset), .vme_as_i(vme_as), .vme_ds_i(vme_ds), .vme_lword_i(vme_lword),
    .vme_write_i(vme_write), .vme_address_mod_i(vme_address_mod), .vme_address_i(vme_address),
    .vme_iack_i(vme_iack), .vme_dtack_o(vme_dtack), .vme_berr_o(vme_berr), .data_oe_o(data_oe),
    .data_dir_o(data_dir), .local_req_o(local_req), .local_write_o(local_write), .local_addr_o(local_addr),
    .local_be_o(local_be), .local_ack_i(local_ack), .local_err_i(local_err), .busy_o(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_dtack"}, vme_dtack, 1);
    check({tag, "_berr"}, vme_berr, 1);
    check({tag, "_oe"}, data_oe, 1);
    check({tag, "_dir"}, data_dir, DIR_IN);
    check({tag, "_req"}, local_req, 0);
    check({tag, "_write"}, local_write, 0);
    check({tag, "_addr"}, local_addr, 0);
    check({tag, "_be"}, local_be, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  always @(negedge clock) begin
    if (local_req) req_seen = 1;
    if (!reset) check("dtack_berr_excl", vme_dtack | vme_berr, 1);
  end
  // resp: 0 ack, 1 err, 2 ack+err together, 3 never answer (timeout)
  task automatic run_cycle(input logic [23:0] a, input logic [5:0] am, input logic lw, input logic wr,
                           input logic iack, input logic [1:0] ds, input int resp, input int dly, input bit rst_ack);
    logic hit, illegal;
    logic [3:0] be;
    int off, n;
    hit = iack && (am inside {6'h39, 6'h3A, 6'h3D, 6'h3E}) && a[23:16] == 8'hF0;
    illegal = !lw && (a[1] || ds != 2'b00);
    off = a[1] ? 2 : 0;
    be = '0;
    if (!lw) be = 4'hF;
    else begin
      if (!ds[1]) be[3-off] = 1'b1;
      if (!ds[0]) be[2-off] = 1'b1;
    end
    req_seen = 0;
    @(negedge clock);
    vme_address = a[23:1]; vme_address_mod = am; vme_lword = lw; vme_write = wr; vme_iack = iack;
    @(negedge clock);
    vme_as = 0;
    @(negedge clock);
    vme_ds = ds;
    if (!hit) begin
      repeat (6) @(negedge clock);
      check("ign_req", req_seen, 0);
      check("ign_dtack", vme_dtack, 1);
      check("ign_berr", vme_berr, 1);
      check("ign_busy", busy, 1);
    end else if (illegal) begin
      n = 0;
      while (vme_berr && n < 20) begin @(negedge clock); n++; end
      check("ill_berr", vme_berr, 0);
      check("ill_req", req_seen, 0);
      check("ill_dtack", vme_dtack, 1);
      check("ill_oe", data_oe, 1);
    end else begin
      n = 0;
      while (!local_req && n < 20) begin @(negedge clock); n++; end
      check("req", local_req, 1);
      check("addr", local_addr, a[23:2]);
      check("be", local_be, be);
      check("lwrite", local_write, !wr);
      check("dir", data_dir, wr ? DIR_OUT : DIR_IN);
      check("oe", data_oe, 0);
      if (resp == 3) begin
        n = 0;
        while (vme_berr && n < TO + 10) begin @(negedge clock); n++; end
        check("to_cycles", n, TO);
        check("to_berr", vme_berr, 0);
        check("to_req", local_req, 0);
        check("to_oe", data_oe, 1);
      end else begin
        repeat (dly) @(negedge clock);
        check("req_hold", local_req, 1);
        local_ack = resp != 1;
        local_err = resp != 0;
        @(negedge clock);
        local_ack = 0; local_err = 0;
        check("resp_req", local_req, 0);
        if (resp == 0) begin
          check("dtack", vme_dtack, 0);
          check("ack_berr", vme_berr, 1);
          check("ack_dir", data_dir, wr ? DIR_OUT : DIR_IN);
          if (wr) check("rd_oe", data_oe, 0);
        end else begin
          check("err_berr", vme_berr, 0);
          check("err_dtack", vme_dtack, 1);
          check("err_oe", data_oe, 1);
        end
        if (rst_ack) begin
          #2 reset = 1;
          #1 check_reset_outputs("rst_ack");
          vme_as = 1; vme_ds = 2'b11;
          @(negedge clock);
          reset = 0;
          repeat (4) @(negedge clock);
          return;
        end
      end
    end
    vme_as = 1; vme_ds = 2'b11;
    if (hit) begin
      n = 0;
      while ((!vme_dtack || !vme_berr) && n < 20) begin @(negedge clock); n++; end
      check("rel_cycles", n, SS + 1);
    end
    repeat (SS + 2) @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_dtack", vme_dtack, 1);
    check("idle_berr", vme_berr, 1);
    check("idle_oe", data_oe, 1);
    check("idle_dir", data_dir, DIR_IN);
    check("idle_req", local_req, 0);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 0;
    repeat (2) @(negedge clock);
    run_cycle(24'hF01234, 6'h3D, 0, 1, 1, 2'b00, 0, 3, 0);
    run_cycle(24'hF00003, 6'h39, 1, 0, 1, 2'b10, 0, 1, 0);
    run_cycle(24'hE00000, 6'h3D, 1, 1, 1, 2'b00, 0, 0, 0);
    run_cycle(24'hF00010, 6'h3E, 0, 1, 1, 2'b00, 3, 0, 0);
    run_cycle(24'hF00002, 6'h3D, 0, 1, 1, 2'b00, 0, 0, 0);
    run_cycle(24'hF00020, 6'h3A, 1, 0, 1, 2'b00, 2, 2, 0);
    run_cycle(24'hF00100, 6'h3D, 1, 1, 0, 2'b00, 0, 0, 0);
    run_cycle(24'hF00040, 6'h3D, 0, 1, 1, 2'b00, 0, 1, 1);
    run_cycle(24'hF00044, 6'h3D, 0, 0, 1, 2'b00, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      logic [23:0] a;
      logic [5:0] am;
      a = 24'($urandom);
      if ($urandom_range(0, 3) != 0) a[23:16] = 8'hF0;
      case ($urandom_range(0, 4))
        0: am = 6'h39;
        1: am = 6'h3A;
        2: am = 6'h3D;
        3: am = 6'h3E;
        default: am = 6'($urandom);
      endcase
      run_cycle(a, am, 1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0,
                2'($urandom_range(0, 2)), $urandom_range(0, 2), $urandom_range(0, 5), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
